irq_ctrl_32: RTL and testbench

Interrupt controller that collects 32 asynchronous interrupt sources, latches and masks them, and uses the 32-to-5 priority encoder `prencoder_32_5` to select the highest-numbered pending source. It presents that source to the core through a request/acknowledge/end-of-interrupt handshake. It sits between peripheral interrupt lines and the core's exception entry logic, and it serialises servicing: one interrupt is in service at a time, with no nesting.

---
 rtl/irq_ctrl_pkg.sv | 24 ++
 rtl/prencoder_32_5.sv | 19 +
 rtl/irq_ctrl_32.sv | 119 +++++++++++
 tb/tb_irq_ctrl_32.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the 32-source interrupt controller.
package irq_ctrl_pkg;

  localparam int IRQ_NSRC = 32;
  localparam int IRQ_ID_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Everything masked out of reset so no source fires before software configures it
  localparam logic [IRQ_NSRC-1:0] MASK_RST = 32'hFFFF_FFFF;

  // One-hot vector with only bit `id` set
  function automatic logic [IRQ_NSRC-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
    logic [IRQ_NSRC-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prencoder_32_5.sv
// 32-to-5 priority encoder: index of the highest set bit, high-impedance when no bit is set.
module prencoder_32_5 (
  input  logic [31:0] din,
  output logic [4:0]  sel_id
);

  logic [4:0] enc;

  // Later (higher) indices overwrite earlier ones, so bit 31 wins
  always_comb begin
    enc = '0;
    for (int i = 0; i < 32; i++) begin
      if (din[i]) enc = 5'(i);
    end
  end

  assign sel_id = (|din) ? enc : 5'bz;

endmodule

// File: rtl/irq_ctrl_32.sv
// Interrupt controller: synchronises 32 sources, latches and masks them, and offers
// the highest-numbered eligible source to the core via req/ack/eoi, one at a time.
module irq_ctrl_32
  import irq_ctrl_pkg::*;
#(
  parameter int EDGE_MODE   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         irq_in,
  input  logic                mask_we,
  input  logic [31:0]         mask_wdata,
  output logic [31:0]         mask_q,
  output logic [31:0]         pend_q,
  output logic                irq_req,
  output logic [4:0]          irq_id,
  input  logic                irq_ack,
  input  logic                irq_eoi,
  output logic                busy
);

  logic [IRQ_NSRC-1:0] sync_q [SYNC_STAGES];
  logic [IRQ_NSRC-1:0] hist_q;
  logic [IRQ_NSRC-1:0] s;
  logic [IRQ_NSRC-1:0] pend_set;
  logic [IRQ_NSRC-1:0] pend_clr;
  logic [IRQ_NSRC-1:0] eligible;
  logic [IRQ_ID_W-1:0] sel_id;
  logic                any_elig;
  logic                ack_take;
  irq_state_e          state;

  assign s        = sync_q[SYNC_STAGES-1];
  assign pend_set = s & ~hist_q;
  assign ack_take = (state == REQ) && irq_ack;
  assign pend_clr = ack_take ? id_onehot(irq_id) : '0;
  assign eligible = pend_q & ~mask_q;
  assign any_elig = |eligible;

  // sel_id floats when nothing is eligible; it is only sampled under any_elig
  prencoder_32_5 u_prenc (
    .din    (eligible),
    .sel_id (sel_id)
  );

  // Synchroniser chain per source plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= s;
    end
  end

  // Pending latch: sticky edges (a new edge beats a coincident ack clear) or raw level follow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else if (EDGE_MODE != 0) begin
      pend_q <= (pend_q & ~pend_clr) | pend_set;
    end else begin
      pend_q <= s;
    end
  end

  // Mask register; masking only gates selection, it never clears pending bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= MASK_RST;
    end else if (mask_we) begin
      mask_q <= mask_wdata;
    end
  end

  // Handshake FSM with registered req/busy/id; the offered id is frozen once in REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      irq_req <= 1'b0;
      busy    <= 1'b0;
      irq_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            state   <= REQ;
            irq_req <= 1'b1;
            irq_id  <= sel_id;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state   <= SERVICE;
            irq_req <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SERVICE: begin
          if (irq_eoi) begin
            state  <= IDLE;
            busy   <= 1'b0;
            irq_id <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
          busy    <= 1'b0;
          irq_id  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl_32.sv
// Scoreboard bench for irq_ctrl_32: stimulus pushes expected request ids (and, where
// known, the cycle they must appear); monitors pop and compare on each new irq_req.
module tb_irq_ctrl_32;

  typedef struct {
    logic [4:0] id;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  // edge-mode instance
  logic [31:0] irq_in, mask_wdata, e_mask, e_pend;
  logic        mask_we, irq_ack, irq_eoi, e_req, e_busy;
  logic [4:0]  e_id;
  // level-mode instance
  logic [31:0] l_irq_in, l_mask_wdata, l_mask, l_pend;
  logic        l_mask_we, l_ack, l_eoi, l_req, l_busy;
  logic [4:0]  l_id;

  exp_t q_e[$];
  exp_t q_l[$];
  exp_t me, ml;
  logic e_prev = 1'b0, l_prev = 1'b0;
  logic [4:0] e_held = '0, l_held = '0;

  irq_ctrl_32 #(.EDGE_MODE(1), .SYNC_STAGES(2)) u_e (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .mask_q(e_mask), .pend_q(e_pend), .irq_req(e_req), .irq_id(e_id),
    .irq_ack(irq_ack), .irq_eoi(irq_eoi), .busy(e_busy)
  );

  irq_ctrl_32 #(.EDGE_MODE(0), .SYNC_STAGES(2)) u_l (
    .clk(clk), .rst_n(rst_n), .irq_in(l_irq_in), .mask_we(l_mask_we), .mask_wdata(l_mask_wdata),
    .mask_q(l_mask), .pend_q(l_pend), .irq_req(l_req), .irq_id(l_id),
    .irq_ack(l_ack), .irq_eoi(l_eoi), .busy(l_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edge-mode monitor
  always @(negedge clk) begin
    if (e_req && !e_prev) begin
      if (q_e.size() == 0) begin
        chk("unexpected_req_e", {27'd0, e_id}, 32'hFFFF_FFFF);
      end else begin
        me = q_e.pop_front();
        chk("req_id_e", {27'd0, e_id}, {27'd0, me.id});
        if (me.cyc >= 0) chk("req_latency_e", cyc, me.cyc);
      end
      e_held = e_id;
    end else if (e_req && e_prev) begin
      chk("frozen_id_e", {27'd0, e_id}, {27'd0, e_held});
    end
    e_prev = e_req;
  end

  // Level-mode monitor
  always @(negedge clk) begin
    if (l_req && !l_prev) begin
      if (q_l.size() == 0) begin
        chk("unexpected_req_l", {27'd0, l_id}, 32'hFFFF_FFFF);
      end else begin
        ml = q_l.pop_front();
        chk("req_id_l", {27'd0, l_id}, {27'd0, ml.id});
        if (ml.cyc >= 0) chk("req_latency_l", cyc, ml.cyc);
      end
      l_held = l_id;
    end else if (l_req && l_prev) begin
      chk("frozen_id_l", {27'd0, l_id}, {27'd0, l_held});
    end
    l_prev = l_req;
  end

  task automatic push(input bit lvl, input logic [4:0] id, input int c);
    exp_t x;
    x.id  = id;
    x.cyc = c;
    if (lvl) q_l.push_back(x); else q_e.push_back(x);
  endtask

  function automatic logic req_of(input bit lvl);
    return lvl ? l_req : e_req;
  endfunction

  function automatic logic busy_of(input bit lvl);
    return lvl ? l_busy : e_busy;
  endfunction

  task automatic write_mask(input bit lvl, input logic [31:0] v);
    if (lvl) begin l_mask_we = 1'b1; l_mask_wdata = v; end
    else begin mask_we = 1'b1; mask_wdata = v; end
    @(negedge clk);
    l_mask_we = 1'b0;
    mask_we   = 1'b0;
  endtask

  task automatic wait_req(input bit lvl);
    int t = 0;
    while (!req_of(lvl) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("wait_req", {31'd0, req_of(lvl)}, 32'd1);
  endtask

  task automatic pulse_ack(input bit lvl, input bit with_eoi);
    if (lvl) begin l_ack = 1'b1; l_eoi = with_eoi; end
    else begin irq_ack = 1'b1; irq_eoi = with_eoi; end
    @(negedge clk);
    l_ack = 1'b0; l_eoi = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;
  endtask

  task automatic pulse_eoi(input bit lvl);
    if (lvl) l_eoi = 1'b1; else irq_eoi = 1'b1;
    @(negedge clk);
    l_eoi = 1'b0; irq_eoi = 1'b0;
  endtask

  // Full handshake; optionally expect the next request exactly one cycle after eoi
  task automatic serve(input bit lvl, input bit next);
    wait_req(lvl);
    pulse_ack(lvl, 1'b0);
    chk("ack_busy", {31'd0, busy_of(lvl)}, 32'd1);
    chk("ack_req_low", {31'd0, req_of(lvl)}, 32'd0);
    pulse_eoi(lvl);
    chk("eoi_busy", {31'd0, busy_of(lvl)}, 32'd0);
    chk("eoi_req_low", {31'd0, req_of(lvl)}, 32'd0);
    if (next) begin
      @(negedge clk);
      chk("rereq_gap", {31'd0, req_of(lvl)}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    irq_in = '0; mask_we = 1'b0; mask_wdata = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
    l_irq_in = '0; l_mask_we = 1'b0; l_mask_wdata = '0; l_ack = 1'b0; l_eoi = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mask", e_mask, 32'hFFFF_FFFF);
    chk("rst_pend", e_pend, 32'h0);
    chk("rst_req", {31'd0, e_req}, 32'd0);
    chk("rst_busy", {31'd0, e_busy}, 32'd0);
    chk("rst_id", {27'd0, e_id}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset defaults: source toggles while masked -> pending but no request
    irq_in = 32'h0000_0010;
    repeat (5) @(negedge clk);
    irq_in = '0;
    chk("dflt_req", {31'd0, e_req}, 32'd0);
    chk("dflt_pend", e_pend, 32'h0000_0010);
    chk("dflt_mask", e_mask, 32'hFFFF_FFFF);

    // Unmasking releases the already-latched source 4
    push(0, 5'd4, -1);
    write_mask(0, 32'h0);
    chk("mask_written", e_mask, 32'h0);
    wait_req(0);
    pulse_ack(0, 1'b0);
    chk("pend4_cleared", {31'd0, e_pend[4]}, 32'd0);
    chk("busy_service", {31'd0, e_busy}, 32'd1);
    pulse_eoi(0);
    chk("idle_after_eoi", {31'd0, e_busy | e_req}, 32'd0);

    // Single request with exact latency: edge driven before edge n -> REQ at n+3
    push(0, 5'd4, cyc + 4);
    irq_in = 32'h0000_0010;
    wait_req(0);
    chk("single_id", {27'd0, e_id}, 32'd4);
    serve(0, 1'b0);
    irq_in = '0;
    repeat (3) @(negedge clk);

    // Priority: 31, then 17, then 3
    push(0, 5'd31, cyc + 4);
    push(0, 5'd17, -1);
    push(0, 5'd3, -1);
    irq_in = 32'h8002_0008;
    serve(0, 1'b1);
    irq_in = '0;
    serve(0, 1'b1);
    serve(0, 1'b0);
    chk("prio_pend_empty", e_pend, 32'h0);

    // Masking and frozen request
    write_mask(0, 32'h8000_0000);
    push(0, 5'd9, -1);
    irq_in = 32'h8000_0200;
    wait_req(0);
    irq_in = 32'h8010_0200;
    push(0, 5'd20, -1);
    repeat (5) @(negedge clk);
    chk("frozen_id9", {27'd0, e_id}, 32'd9);
    serve(0, 1'b1);
    serve(0, 1'b0);
    irq_in = '0;
    repeat (3) @(negedge clk);

    // New source-2 edge coinciding with the ack of id 2: set wins
    push(0, 5'd2, cyc + 4);
    irq_in = 32'h0000_0004;
    wait_req(0);
    irq_in = '0;
    repeat (4) @(negedge clk);
    irq_in = 32'h0000_0004;
    @(negedge clk);
    @(negedge clk);
    pulse_ack(0, 1'b0);
    chk("set_beats_clr", {31'd0, e_pend[2]}, 32'd1);
    chk("coinc_busy", {31'd0, e_busy}, 32'd1);
    push(0, 5'd2, -1);
    pulse_eoi(0);
    @(negedge clk);
    chk("rereq_after_eoi", {31'd0, e_req}, 32'd1);
    irq_in = '0;
    serve(0, 1'b0);

    // ack and eoi together in REQ: ack taken, eoi dropped
    push(0, 5'd5, -1);
    irq_in = 32'h0000_0020;
    wait_req(0);
    pulse_ack(0, 1'b1);
    chk("ackeoi_busy", {31'd0, e_busy}, 32'd1);
    chk("ackeoi_req", {31'd0, e_req}, 32'd0);
    pulse_eoi(0);
    chk("ackeoi_done", {31'd0, e_busy}, 32'd0);
    irq_in = '0;

    // Stray eoi / ack in IDLE have no effect
    pulse_eoi(0);
    pulse_ack(0, 1'b0);
    repeat (2) @(negedge clk);
    chk("stray_busy", {31'd0, e_busy}, 32'd0);
    chk("stray_req", {31'd0, e_req}, 32'd0);
    chk("stray_pend", e_pend, 32'h8000_0000);

    // Level mode: held source re-requests right after eoi, ack does not clear it
    write_mask(1, 32'h0);
    push(1, 5'd0, cyc + 4);
    l_irq_in = 32'h0000_0001;
    wait_req(1);
    push(1, 5'd0, -1);
    pulse_ack(1, 1'b0);
    chk("lvl_pend_held", {31'd0, l_pend[0]}, 32'd1);
    chk("lvl_busy", {31'd0, l_busy}, 32'd1);
    pulse_eoi(1);
    @(negedge clk);
    chk("lvl_rereq", {31'd0, l_req}, 32'd1);
    pulse_ack(1, 1'b0);
    l_irq_in = '0;
    repeat (4) @(negedge clk);
    chk("lvl_pend_drop", l_pend, 32'h0);
    pulse_eoi(1);
    repeat (3) @(negedge clk);
    chk("lvl_quiet", {30'd0, l_req, l_busy}, 32'd0);

    // Asynchronous reset in SERVICE
    push(0, 5'd6, -1);
    irq_in = 32'h0000_0040;
    wait_req(0);
    pulse_ack(0, 1'b0);
    irq_in = 32'h0000_00C0;
    repeat (4) @(negedge clk);
    chk("pre_rst_pend7", {31'd0, e_pend[7]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, e_busy}, 32'd0);
    chk("arst_req", {31'd0, e_req}, 32'd0);
    chk("arst_id", {27'd0, e_id}, 32'd0);
    chk("arst_pend", e_pend, 32'h0);
    chk("arst_mask", e_mask, 32'hFFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b1;
    irq_in = '0;
    repeat (4) @(negedge clk);
    chk("post_rst_req", {31'd0, e_req}, 32'd0);

    chk("queue_empty_e", q_e.size(), 32'd0);
    chk("queue_empty_l", q_l.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
